// File: rtl/sharp_pkg.sv
// Shared constants and encodings for the 3x3 sharpening window generator.
// Holds the default geometry, the FSM state encoding and the mode field values.
package sharp_pkg;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_IMG_W = 16;
    localparam int DEF_IMG_H = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Mode is carried through untouched; the kernel downstream interprets it.
    localparam logic [1:0] MODE_NONE   = 2'b00;
    localparam logic [1:0] MODE_LIGHT  = 2'b01;
    localparam logic [1:0] MODE_MEDIUM = 2'b10;
    localparam logic [1:0] MODE_STRONG = 2'b11;

endpackage

// File: rtl/sharp_window_gen_if.sv
// Pixel-in / window-out bundle of the window generator.
// The slave modport is the generator, the master modport is its environment.
interface sharp_window_gen_if #(
    parameter int PIX_W = sharp_pkg::DEF_PIX_W
);
    logic                 START;
    logic [1:0]           MODE_IN;
    logic [PIX_W-1:0]     PIX_IN;
    logic                 PIX_VALID;
    logic                 PIX_READY;
    logic [9*PIX_W-1:0]   WIN;
    logic                 WIN_VALID;
    logic                 WIN_READY;
    logic [1:0]           MODE_OUT;
    logic                 FRAME_DONE;

    modport master (
        output START, MODE_IN, PIX_IN, PIX_VALID, WIN_READY,
        input  PIX_READY, WIN, WIN_VALID, MODE_OUT, FRAME_DONE
    );

    modport slave (
        input  START, MODE_IN, PIX_IN, PIX_VALID, WIN_READY,
        output PIX_READY, WIN, WIN_VALID, MODE_OUT, FRAME_DONE
    );
endinterface

// File: rtl/sharp_line_fifo.sv
// One-line pixel delay: the output is the pixel shifted in DEPTH enables earlier.
// Two of these in series supply the rows above the incoming pixel.
module sharp_line_fifo #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             shift_en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);
    logic [PIX_W-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; every entry is rewritten before any window uses it.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout = mem_q[DEPTH-1];
endmodule

// File: rtl/sharp_window_gen.sv
// Raster-scan 3x3 window generator: two line delays plus per-row column shifters,
// with a one-deep registered window output under valid/ready flow control.
module sharp_window_gen
    import sharp_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic               CLK,
    input  logic               RST_N,
    sharp_window_gen_if.slave  bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef logic [PIX_W-1:0] pix_t;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    mode_q, mode_d;
    pix_t          sh_q [3][2];
    pix_t          sh_d [3][2];
    pix_t          win_q [9];
    pix_t          win_d [9];
    logic          win_valid_q, win_valid_d;

    logic pix_ready, accept, win_fire, frame_done;
    pix_t line1, line2;
    pix_t new_col [3];

    sharp_line_fifo #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_line1 (
        .clk(CLK), .shift_en(accept), .din(bus.PIX_IN), .dout(line1)
    );
    sharp_line_fifo #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_line2 (
        .clk(CLK), .shift_en(accept), .din(line1), .dout(line2)
    );

    // Newest column, top to bottom: two rows up, one row up, current pixel.
    assign new_col[0] = line2;
    assign new_col[1] = line1;
    assign new_col[2] = bus.PIX_IN;

    assign pix_ready = (state_q == ST_RUN) && (!win_valid_q || bus.WIN_READY);
    assign accept    = pix_ready && bus.PIX_VALID;
    assign win_fire  = win_valid_q && bus.WIN_READY;

    // NOTE: every signal gets its default before the case, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        sh_d        = sh_q;
        win_d       = win_q;
        win_valid_d = win_valid_q && !win_fire;
        frame_done  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = ST_RUN;
                    col_d   = '0;
                    row_d   = '0;
                    mode_d  = bus.MODE_IN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    // At the start of a line the older columns are cleared so no
                    // pixel of the previous line can reach a window.
                    for (int r = 0; r < 3; r++) begin
                        sh_d[r][0] = (col_q == '0) ? '0 : sh_q[r][1];
                        sh_d[r][1] = new_col[r];
                    end
                    if (row_q >= RW'(2) && col_q >= CW'(2)) begin
                        win_valid_d = 1'b1;
                        for (int r = 0; r < 3; r++) begin
                            win_d[r*3 + 0] = sh_q[r][0];
                            win_d[r*3 + 1] = sh_q[r][1];
                            win_d[r*3 + 2] = new_col[r];
                        end
                    end
                    if (row_q == ROW_LAST && col_q == COL_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!win_valid_q || win_fire) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= MODE_NONE;
            win_valid_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                sh_q[r][0] <= '0;
                sh_q[r][1] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            win_valid_q <= win_valid_d;
            sh_q        <= sh_d;
            win_q       <= win_d;
        end
    end

    // Top-left pixel lands in the most significant slice.
    always_comb begin
        bus.WIN = '0;
        for (int k = 0; k < 9; k++) begin
            bus.WIN[(8-k)*PIX_W +: PIX_W] = win_q[k];
        end
    end

    assign bus.PIX_READY  = pix_ready;
    assign bus.WIN_VALID  = win_valid_q;
    assign bus.MODE_OUT   = mode_q;
    assign bus.FRAME_DONE = frame_done;
endmodule

// File: tb/tb_sharp_window_gen.sv
// Directed bench for sharp_window_gen: a 4x4 instance for the hand-computed
// scenarios and a 16x16 instance fed with random gaps against an image model.
module tb_sharp_window_gen;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    sharp_window_gen_if #(.PIX_W(8)) if4 ();
    sharp_window_gen_if #(.PIX_W(8)) if16 ();

    sharp_window_gen #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) u_dut4 (
        .CLK(CLK), .RST_N(RST_N), .bus(if4.slave)
    );
    sharp_window_gen #(.PIX_W(8), .IMG_W(16), .IMG_H(16)) u_dut16 (
        .CLK(CLK), .RST_N(RST_N), .bus(if16.slave)
    );

    int tests = 0;
    int fails = 0;

    logic [71:0] got_win [$];
    logic [1:0]  got_mode [$];
    int          done_cnt;

    logic [71:0] exp4 [4] = '{
        {8'd0, 8'd1, 8'd2,  8'd4, 8'd5,  8'd6,  8'd8,  8'd9,  8'd10},
        {8'd1, 8'd2, 8'd3,  8'd5, 8'd6,  8'd7,  8'd9,  8'd10, 8'd11},
        {8'd4, 8'd5, 8'd6,  8'd8, 8'd9,  8'd10, 8'd12, 8'd13, 8'd14},
        {8'd5, 8'd6, 8'd7,  8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}
    };

    // mid_action: 0 none, 1 change MODE_IN mid-frame, 2 also pulse START mid-frame.
    // abort_at >= 0 pulls RST_N low once that many pixels were accepted.
    task automatic drive_frame4(input logic [1:0] mode, input int stall_len,
                                input int mid_action, input int abort_at);
        int pix = 0;
        int cyc = 0;
        bit done = 1'b0;
        bit stall_started = 1'b0;
        bit sent = 1'b0;
        int stall_left = 0;
        logic [71:0] held = '0;
        got_win.delete();
        got_mode.delete();
        done_cnt = 0;
        @(posedge CLK); #1;
        if4.START = 1'b1;
        if4.MODE_IN = mode;
        @(posedge CLK); #1;
        if4.START = 1'b0;
        while (!done && cyc < 200) begin
            if (abort_at >= 0 && pix == abort_at) begin
                RST_N = 1'b0;
                if4.PIX_VALID = 1'b0;
                return;
            end
            if (mid_action != 0 && !sent && pix == 6) begin
                if4.MODE_IN = 2'b01;
                if4.START = (mid_action == 2);
                sent = 1'b1;
            end
            if (stall_len > 0 && !stall_started && if4.WIN_VALID) begin
                stall_started = 1'b1;
                stall_left = stall_len;
                held = if4.WIN;
            end
            if4.WIN_READY = (stall_left == 0);
            if4.PIX_VALID = (pix < 16);
            if4.PIX_IN = 8'(pix);
            @(negedge CLK);
            if (stall_left > 0) begin
                tests++;
                if (if4.PIX_READY !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_pix_ready got %0b want 0", if4.PIX_READY);
                end
                tests++;
                if (if4.WIN !== held) begin
                    fails++;
                    $display("FAIL stall_win_stable got %h want %h", if4.WIN, held);
                end
                stall_left--;
            end
            if (if4.PIX_VALID && if4.PIX_READY) pix++;
            if (if4.WIN_VALID && if4.WIN_READY) begin
                got_win.push_back(if4.WIN);
                got_mode.push_back(if4.MODE_OUT);
            end
            if (if4.FRAME_DONE) begin
                done_cnt++;
                done = 1'b1;
            end
            @(posedge CLK); #1;
            if4.START = 1'b0;
            cyc++;
        end
        if4.PIX_VALID = 1'b0;
        if4.WIN_READY = 1'b1;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL frame_timeout got no FRAME_DONE within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        tests++;
        if ({if4.WIN_VALID, if4.PIX_READY, if4.FRAME_DONE} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b want 000",
                     {if4.WIN_VALID, if4.PIX_READY, if4.FRAME_DONE});
        end
        tests++;
        if (if4.MODE_OUT !== 2'b00 || if4.WIN !== 72'd0) begin
            fails++;
            $display("FAIL reset_data got mode %b win %h want 00 / 0", if4.MODE_OUT, if4.WIN);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
    endtask

    task automatic test_basic_frame();
        drive_frame4(2'b11, 0, 0, -1);
        tests++;
        if (got_win.size() != 4) begin
            fails++;
            $display("FAIL basic_count got %0d want 4", got_win.size());
        end
        for (int i = 0; i < got_win.size() && i < 4; i++) begin
            tests++;
            if (got_win[i] !== exp4[i]) begin
                fails++;
                $display("FAIL basic_win%0d got %h want %h", i, got_win[i], exp4[i]);
            end
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL basic_done_count got %0d want 1", done_cnt);
        end
        @(negedge CLK);
        tests++;
        if (if4.FRAME_DONE !== 1'b0 || if4.PIX_READY !== 1'b0) begin
            fails++;
            $display("FAIL basic_after_done got done %b ready %b want 0 0",
                     if4.FRAME_DONE, if4.PIX_READY);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_backpressure();
        drive_frame4(2'b00, 5, 0, -1);
        tests++;
        if (got_win.size() != 4) begin
            fails++;
            $display("FAIL bp_count got %0d want 4", got_win.size());
        end
        for (int i = 0; i < got_win.size() && i < 4; i++) begin
            tests++;
            if (got_win[i] !== exp4[i]) begin
                fails++;
                $display("FAIL bp_win%0d got %h want %h", i, got_win[i], exp4[i]);
            end
        end
    endtask

    task automatic test_mode_capture();
        drive_frame4(2'b10, 0, 1, -1);
        tests++;
        if (got_mode.size() != 4) begin
            fails++;
            $display("FAIL mode_count got %0d want 4", got_mode.size());
        end
        for (int i = 0; i < got_mode.size(); i++) begin
            tests++;
            if (got_mode[i] !== 2'b10) begin
                fails++;
                $display("FAIL mode_win%0d got %b want 10", i, got_mode[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        drive_frame4(2'b11, 0, 2, -1);
        tests++;
        if (got_win.size() != 4 || done_cnt != 1) begin
            fails++;
            $display("FAIL ign_count got %0d windows %0d done want 4 1", got_win.size(), done_cnt);
        end
        for (int i = 0; i < got_win.size() && i < 4; i++) begin
            tests++;
            if (got_win[i] !== exp4[i] || got_mode[i] !== 2'b11) begin
                fails++;
                $display("FAIL ign_win%0d got %h mode %b want %h mode 11",
                         i, got_win[i], got_mode[i], exp4[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        drive_frame4(2'b11, 0, 0, 10);
        @(negedge CLK);
        tests++;
        if ({if4.WIN_VALID, if4.PIX_READY, if4.FRAME_DONE} !== 3'b000 ||
            if4.MODE_OUT !== 2'b00 || if4.WIN !== 72'd0) begin
            fails++;
            $display("FAIL abort_outputs got v%b r%b d%b mode %b win %h want all 0",
                     if4.WIN_VALID, if4.PIX_READY, if4.FRAME_DONE, if4.MODE_OUT, if4.WIN);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        if4.PIX_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            tests++;
            if (if4.PIX_READY !== 1'b0 || if4.FRAME_DONE !== 1'b0) begin
                fails++;
                $display("FAIL abort_needs_start got ready %b done %b want 0 0",
                         if4.PIX_READY, if4.FRAME_DONE);
            end
        end
        @(posedge CLK); #1;
        if4.PIX_VALID = 1'b0;
        tests++;
        if (done_cnt != 0) begin
            fails++;
            $display("FAIL abort_done got %0d want 0", done_cnt);
        end
        drive_frame4(2'b00, 0, 0, -1);
        tests++;
        if (got_win.size() != 4) begin
            fails++;
            $display("FAIL abort_refr_count got %0d want 4", got_win.size());
        end
        for (int i = 0; i < got_win.size() && i < 4; i++) begin
            tests++;
            if (got_win[i] !== exp4[i]) begin
                fails++;
                $display("FAIL abort_refr_win%0d got %h want %h", i, got_win[i], exp4[i]);
            end
        end
    endtask

    task automatic test_random_gaps();
        logic [7:0]  img [16][16];
        logic [71:0] exp_w;
        int exp_r = 2;
        int exp_c = 2;
        int n = 0;
        int pix = 0;
        int cyc = 0;
        int dones = 0;
        bit done = 1'b0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                img[r][c] = 8'($urandom);
        @(posedge CLK); #1;
        if16.START = 1'b1;
        if16.MODE_IN = 2'b01;
        @(posedge CLK); #1;
        if16.START = 1'b0;
        while (!done && cyc < 4000) begin
            if16.PIX_VALID = (pix < 256) && ($urandom_range(0, 2) != 0);
            if16.PIX_IN = (pix < 256) ? img[pix / 16][pix % 16] : 8'd0;
            if16.WIN_READY = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            if (if16.PIX_VALID && if16.PIX_READY) pix++;
            if (if16.WIN_VALID && if16.WIN_READY) begin
                if (n < 196) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            exp_w[(8 - (i*3 + j))*8 +: 8] = img[exp_r-2+i][exp_c-2+j];
                    tests++;
                    if (if16.WIN !== exp_w) begin
                        fails++;
                        $display("FAIL rand_win%0d got %h want %h", n, if16.WIN, exp_w);
                    end
                    exp_c++;
                    if (exp_c == 16) begin
                        exp_c = 2;
                        exp_r++;
                    end
                end
                n++;
            end
            if (if16.FRAME_DONE) begin
                dones++;
                done = 1'b1;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        if16.PIX_VALID = 1'b0;
        tests++;
        if (n != 196 || dones != 1) begin
            fails++;
            $display("FAIL rand_count got %0d windows %0d done want 196 1", n, dones);
        end
    endtask

    initial begin
        if4.START = 1'b0;   if4.MODE_IN = 2'b00;  if4.PIX_IN = 8'd0;
        if4.PIX_VALID = 1'b0; if4.WIN_READY = 1'b1;
        if16.START = 1'b0;  if16.MODE_IN = 2'b00; if16.PIX_IN = 8'd0;
        if16.PIX_VALID = 1'b0; if16.WIN_READY = 1'b1;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_mode_capture();
        test_ignored_start();
        test_reset_abort();
        test_random_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
